// File: rtl/btn_pkg.sv
// btn_pkg: shared types and helpers for the button debounce reader
//   btn_state_e  per-channel debounce state
//   ms_to_cyc    converts a millisecond interval into clock cycles
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DB_PRESS,
        HELD,
        DB_RELEASE
    } btn_state_e;

    // Divide before multiplying so large CLK_HZ * ms products cannot overflow.
    function automatic longint ms_to_cyc(input longint hz, input longint ms);
        return hz / 64'sd1000 * ms;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// btn_channel: synchroniser, debounce state machine and hold timer for one button
//   clk        board clock, rising edge
//   rst_n      asynchronous active-low reset
//   i_pressed  raw pin normalised so that 1 = pressed
//   o_level    debounced level, 1 = pressed
//   o_press    one-cycle pulse on an accepted press
//   o_release  one-cycle pulse on an accepted release
//   o_long     one-cycle pulse once per press held long enough
//   Macro BTN_LONG_PRESS_EN compiles in the hold counter and o_long.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DB_CYC   = 4,
    parameter int LONG_CYC = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pressed,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam int DB_W = $clog2(DB_CYC + 1);
    // The cycle spent in IDLE or HELD already counts as the first stable
    // sample, so the counter only covers the remaining DB_CYC-1 samples.
    localparam logic [DB_W-1:0] DB_LAST = DB_W'((DB_CYC > 1) ? DB_CYC - 2 : 0);
    localparam bit DB_ONE = (DB_CYC == 1);

    if (DB_CYC < 1 || LONG_CYC <= DB_CYC) begin : g_bad_cfg
        $error("btn_channel: requires DB_CYC >= 1 and LONG_CYC > DB_CYC");
    end

    logic            r_sync1;
    logic            r_sync2;
    btn_state_e      r_state;
    btn_state_e      w_state_nxt;
    logic [DB_W-1:0] r_db_cnt;
    logic [DB_W-1:0] w_db_nxt;
    logic            r_level;
    logic            w_level_nxt;
    logic            r_press;
    logic            w_press_nxt;
    logic            r_release;
    logic            w_release_nxt;

    always_comb begin
        w_state_nxt   = r_state;
        w_db_nxt      = r_db_cnt;
        w_level_nxt   = r_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_sync2 && DB_ONE) begin
                    w_state_nxt = HELD;
                    w_level_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                end else if (r_sync2) begin
                    w_state_nxt = DB_PRESS;
                    w_db_nxt    = '0;
                end
            end
            DB_PRESS: begin
                if (!r_sync2) begin
                    w_state_nxt = IDLE;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_nxt = HELD;
                    w_level_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                end else begin
                    w_db_nxt = r_db_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!r_sync2 && DB_ONE) begin
                    w_state_nxt   = IDLE;
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                end else if (!r_sync2) begin
                    w_state_nxt = DB_RELEASE;
                    w_db_nxt    = '0;
                end
            end
            DB_RELEASE: begin
                if (r_sync2) begin
                    w_state_nxt = HELD;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_nxt   = IDLE;
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_db_nxt = r_db_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_state   <= IDLE;
            r_db_cnt  <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= i_pressed;
            r_sync2   <= r_sync1;
            r_state   <= w_state_nxt;
            r_db_cnt  <= w_db_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

`ifdef BTN_LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_CYC + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYC);
    // Hold counting starts at the press pulse, which already trails the
    // synchronised press by DB_CYC cycles.
    localparam logic [HOLD_W-1:0] HOLD_LONG = HOLD_W'(LONG_CYC - DB_CYC);

    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              r_long;
    logic              w_long_nxt;

    // Saturating at HOLD_MAX (above HOLD_LONG) keeps the long pulse to one
    // per press; the count survives release bounces for the same reason.
    always_comb begin
        w_hold_nxt = r_hold_cnt;
        w_long_nxt = 1'b0;
        if (w_press_nxt) begin
            w_hold_nxt = '0;
        end else if (r_state == HELD && r_hold_cnt != HOLD_MAX) begin
            w_hold_nxt = r_hold_cnt + 1'b1;
            w_long_nxt = (w_hold_nxt == HOLD_LONG);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
            r_long     <= 1'b0;
        end else begin
            r_hold_cnt <= w_hold_nxt;
            r_long     <= w_long_nxt;
        end
    end

    assign o_long = r_long;
`else
    assign o_long = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce_reader.sv
// btn_debounce_reader: debounced push-button reader with press/release/long-press pulses
//   clk            board clock, rising edge
//   rst_n          asynchronous active-low reset
//   btn_raw        raw asynchronous button pins
//   btn_level      debounced state per button, 1 = pressed
//   press_pulse    one-cycle pulse per accepted press
//   release_pulse  one-cycle pulse per accepted release
//   long_pulse     one-cycle pulse once per press held >= LONG_MS
//   Macro BTN_LONG_PRESS_EN enables long-press detection; otherwise long_pulse is 0.
module btn_debounce_reader
    import btn_pkg::*;
#(
    parameter int N_BTN       = 3,
    parameter int CLK_HZ      = 27000000,
    parameter int DEBOUNCE_MS = 10,
    parameter int LONG_MS     = 1000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_pulse
);

    localparam int DB_CYC   = int'(ms_to_cyc(longint'(CLK_HZ), longint'(DEBOUNCE_MS)));
    localparam int LONG_CYC = int'(ms_to_cyc(longint'(CLK_HZ), longint'(LONG_MS)));

    logic [N_BTN-1:0] w_pressed;

    assign w_pressed = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DB_CYC   (DB_CYC),
            .LONG_CYC (LONG_CYC)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_pressed (w_pressed[i]),
            .o_level   (btn_level[i]),
            .o_press   (press_pulse[i]),
            .o_release (release_pulse[i]),
            .o_long    (long_pulse[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce_reader.sv
// tb_btn_debounce_reader: table, directed and randomized checks against a run-length reference model
module tb_btn_debounce_reader;

    localparam int AL = 1;
    localparam int DB = 4;
    localparam int LC = 20;
`ifdef BTN_LONG_PRESS_EN
    localparam int LONG_EN = 1;
`else
    localparam int LONG_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] btn_raw = 3'b111;
    logic [2:0] btn_level, press_pulse, release_pulse, long_pulse;

    btn_debounce_reader #(
        .N_BTN       (3),
        .CLK_HZ      (1000),
        .DEBOUNCE_MS (4),
        .LONG_MS     (20),
        .ACTIVE_LOW  (AL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_raw       (btn_raw),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_press, n_rel, n_long, n_lvl;
    int cyc = 0;
    int t_press2, t_long2;

    // Reference model: the debounced level flips once the delayed pin has
    // disagreed with it for DB consecutive samples; hold time counts the
    // samples spent pressed and undisturbed after the press.
    logic [2:0] m_lvl, m_press, m_rel, m_long;
    int run[3];
    int hold[3];
    bit h1[3], h2[3], fired[3];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_lvl = '0; m_press = '0; m_rel = '0; m_long = '0;
        for (int c = 0; c < 3; c++) begin
            run[c] = 0; hold[c] = 0; h1[c] = 0; h2[c] = 0; fired[c] = 0;
        end
    endfunction

    function automatic void model_step(input logic [2:0] raw);
        m_press = '0; m_rel = '0; m_long = '0;
        for (int c = 0; c < 3; c++) begin
            bit p, x, steady;
            p = (AL != 0) ? ~raw[c] : raw[c];
            x = h2[c];
            h2[c] = h1[c];
            h1[c] = p;
            steady = (run[c] == 0);
            run[c] = (x != m_lvl[c]) ? run[c] + 1 : 0;
            if (run[c] == DB) begin
                m_lvl[c] = x;
                run[c] = 0;
                if (x) begin
                    m_press[c] = 1'b1; hold[c] = 0; fired[c] = 0;
                end else begin
                    m_rel[c] = 1'b1;
                end
            end else if (m_lvl[c] && steady) begin
                hold[c]++;
                if (LONG_EN != 0 && !fired[c] && hold[c] == LC - DB) begin
                    m_long[c] = 1'b1; fired[c] = 1;
                end
            end
        end
    endfunction

    task automatic clr();
        n_press = 0; n_rel = 0; n_long = 0; n_lvl = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_n) model_reset();
        else model_step(btn_raw);
        check("model", 32'({btn_level, press_pulse, release_pulse, long_pulse}),
              32'({m_lvl, m_press, m_rel, m_long}));
        n_press += $countones(press_pulse);
        n_rel   += $countones(release_pulse);
        n_long  += $countones(long_pulse);
        n_lvl   += $countones(btn_level);
        if (press_pulse[2]) t_press2 = cyc;
        if (long_pulse[2]) t_long2 = cyc;
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_async", 32'({btn_level, press_pulse, release_pulse, long_pulse}), 32'h0);
    endtask

    typedef struct {
        logic [2:0] raw;
        int         cyc;
        logic [2:0] lvl;
        int         np;
        int         nr;
        int         nl;
    } vec_t;

    vec_t vec[7];

    initial begin
        vec[0] = '{3'b111, 10, 3'b000, 0, 0, 0};
        vec[1] = '{3'b110,  8, 3'b001, 1, 0, 0};
        vec[2] = '{3'b110, 30, 3'b001, 0, 0, LONG_EN};
        vec[3] = '{3'b111,  8, 3'b000, 0, 1, 0};
        vec[4] = '{3'b010,  8, 3'b101, 2, 0, 0};
        vec[5] = '{3'b111,  3, 3'b101, 0, 0, 0};
        vec[6] = '{3'b111,  5, 3'b000, 0, 2, 0};

        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) tick();
        check("reset_out", 32'({btn_level, press_pulse, release_pulse, long_pulse}), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            btn_raw = vec[i].raw;
            clr();
            repeat (vec[i].cyc) tick();
            check($sformatf("vec%0d_level", i), 32'(btn_level), 32'(vec[i].lvl));
            check($sformatf("vec%0d_press", i), n_press, vec[i].np);
            check($sformatf("vec%0d_release", i), n_rel, vec[i].nr);
            check($sformatf("vec%0d_long", i), n_long, vec[i].nl);
        end

        // exact press latency and one-cycle width
        btn_raw = 3'b110;
        clr();
        repeat (5) tick();
        check("lat_early", n_press, 0);
        tick();
        check("lat_press", 32'(press_pulse), 32'(3'b001));
        check("lat_level", 32'(btn_level), 32'(3'b001));
        tick();
        check("press_width", 32'(press_pulse), 32'h0);

        // 2-cycle release glitch while held
        clr();
        btn_raw = 3'b111;
        repeat (2) tick();
        btn_raw = 3'b110;
        repeat (12) tick();
        check("glitch_release", n_rel, 0);
        check("glitch_press", n_press, 0);
        check("glitch_level", 32'(btn_level), 32'(3'b001));

        // reset mid-hold, button still held through deassertion
        async_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        clr();
        repeat (5) tick();
        check("rst_repress_early", n_press, 0);
        tick();
        check("rst_repress", 32'(press_pulse), 32'(3'b001));
        btn_raw = 3'b111;
        repeat (8) tick();

        // simultaneous presses on channels 0 and 2
        btn_raw = 3'b010;
        repeat (5) tick();
        tick();
        check("simul_press", 32'(press_pulse), 32'(3'b101));
        btn_raw = 3'b111;
        repeat (8) tick();

        // bounce on channel 1: toggles every 2 cycles
        clr();
        for (int i = 0; i < 20; i++) begin
            btn_raw[1] = ((i / 2) % 2) != 0;
            tick();
        end
        btn_raw = 3'b111;
        repeat (8) tick();
        check("bounce_activity", n_press + n_rel + n_long + n_lvl, 0);

        // long press on channel 2
        clr();
        t_press2 = -1;
        t_long2 = -1;
        btn_raw = 3'b011;
        repeat (40) tick();
        btn_raw = 3'b111;
        repeat (8) tick();
        check("long_press_cnt", n_press, 1);
        check("long_long_cnt", n_long, LONG_EN);
        check("long_release_cnt", n_rel, 1);
        check("long_time", t_long2, (LONG_EN != 0) ? t_press2 + (LC - DB) : -1);

        // randomized segments
        for (int s = 0; s < 200; s++) begin
            int len;
            btn_raw = 3'($urandom);
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 6);
            if (s == 100) begin
                async_reset();
                tick();
                rst_n = 1'b1;
            end
            repeat (len) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
